// File: rtl/bs_mult_ctrl.sv
// Sequencer for the bit-serial multiplier array: streams operands LSB-first,
// drives the row token and clear strobe, and gathers the serial product.
module bs_mult_ctrl #(
    parameter int W   = 8,
    parameter int LAT = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_a,
    input  logic [W-1:0]   in_b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] out_prod,
    output logic           bs_x,
    output logic           bs_y,
    output logic           bs_rin,
    output logic           bs_lastbit,
    input  logic           bs_p
);

    localparam int CW = $clog2(2*W+LAT+1);
    localparam logic [CW-1:0] CNT_LAST = CW'(2*W+LAT-1);
    localparam logic [CW-1:0] CNT_LAT  = CW'(LAT);

    localparam logic [2:0] S_INIT  = 3'd0;
    localparam logic [2:0] S_IDLE  = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_FLUSH = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]     state;
    logic [W-1:0]   sa;
    logic [W-1:0]   sb;
    logic [CW-1:0]  cnt;
    logic [2*W-1:0] pr;

    assign in_ready = (state == S_IDLE);
    assign out_prod = pr;

    // Array-facing bits are registered one cycle ahead, so the shift
    // registers are loaded pre-shifted and bit 0 goes straight to bs_x/bs_y.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_INIT;
            sa         <= '0;
            sb         <= '0;
            cnt        <= '0;
            pr         <= '0;
            out_valid  <= 1'b0;
            bs_x       <= 1'b0;
            bs_y       <= 1'b0;
            bs_rin     <= 1'b0;
            bs_lastbit <= 1'b1;
        end else begin
            bs_rin     <= 1'b0;
            bs_lastbit <= 1'b0;
            case (state)
                S_INIT: begin
                    state <= S_IDLE;
                end
                S_IDLE: begin
                    if (in_valid) begin
                        state  <= S_SHIFT;
                        sa     <= in_a >> 1;
                        sb     <= in_b >> 1;
                        bs_x   <= in_a[0];
                        bs_y   <= in_b[0];
                        bs_rin <= 1'b1;
                        cnt    <= '0;
                        pr     <= '0;
                    end
                end
                S_SHIFT: begin
                    bs_x <= sa[0];
                    bs_y <= sb[0];
                    sa   <= sa >> 1;
                    sb   <= sb >> 1;
                    if (cnt >= CNT_LAT)
                        pr <= {bs_p, pr[2*W-1:1]};
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        state      <= S_FLUSH;
                        bs_lastbit <= 1'b1;
                        bs_x       <= 1'b0;
                        bs_y       <= 1'b0;
                    end
                end
                S_FLUSH: begin
                    state     <= S_DONE;
                    out_valid <= 1'b1;
                end
                S_DONE: begin
                    if (out_ready) begin
                        state     <= S_IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state <= S_INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bs_mult_ctrl.sv
// Bench for bs_mult_ctrl with a behavioural serial multiplier array.
module tb_bs_mult_ctrl;

    localparam int W   = 8;
    localparam int LAT = 1;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   in_a = '0;
    logic [W-1:0]   in_b = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [2*W-1:0] out_prod;
    logic           bs_x;
    logic           bs_y;
    logic           bs_rin;
    logic           bs_lastbit;
    logic           bs_p = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    bs_mult_ctrl #(.W(W), .LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_prod(out_prod),
        .bs_x(bs_x), .bs_y(bs_y), .bs_rin(bs_rin),
        .bs_lastbit(bs_lastbit), .bs_p(bs_p)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Array model: remembers the operand bits seen since the row token and
    // emits bit (k-LAT) of their product in cycle k of the sequence.
    logic         mact = 1'b0;
    int           midx = 0;
    logic [W-1:0] ma = '0;
    logic [W-1:0] mb = '0;
    logic         act;
    int           k;
    logic [W-1:0] na;
    logic [W-1:0] nb;

    function automatic logic pbit(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input int j);
        logic [2*W-1:0] p;
        p = (2*W)'(a) * (2*W)'(b);
        if (j < 0 || j >= 2*W) return 1'b0;
        return p[j];
    endfunction

    always_comb begin
        act = bs_rin | mact;
        k   = bs_rin ? 0 : midx;
        na  = bs_rin ? '0 : ma;
        nb  = bs_rin ? '0 : mb;
        if (k < W) begin
            na = na | (W'(bs_x) << k);
            nb = nb | (W'(bs_y) << k);
        end
    end

    always @(negedge clk) begin
        if (bs_lastbit || !act) begin
            mact <= 1'b0;
            bs_p <= 1'b0;
        end else begin
            mact <= 1'b1;
            midx <= k + 1;
            ma   <= na;
            mb   <= nb;
            bs_p <= (k >= LAT) ? pbit(na, nb, k - LAT) : 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full transaction; returns the cycle stamp of the accept.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2*W-1:0] exp, input int hold,
                          input bit inject, output int acc);
        int n;
        int rins;
        int lbs;
        bit seen;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        acc = cyc;
        @(negedge clk);
        in_valid = 1'b0;
        in_a = W'($urandom);
        in_b = W'($urandom);
        n = 0; rins = 0; lbs = 0; seen = 1'b0;
        while (n < 100 && !seen) begin
            n++;
            if (bs_rin) rins++;
            if (bs_lastbit) lbs++;
            if (inject && n == 3) begin
                in_valid = 1'b1;
                in_a = 8'h11;
                in_b = 8'h11;
                chk("busy_ready", 32'(in_ready), 32'd0);
            end
            if (inject && n == 6) in_valid = 1'b0;
            if (out_valid) seen = 1'b1;
            else @(negedge clk);
        end
        chk("latency", 32'(n), 32'(2*W+LAT+2));
        chk("rin_count", 32'(rins), 32'd1);
        chk("lastbit_count", 32'(lbs), 32'd1);
        chk("product", 32'(out_prod), 32'(exp));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_prod", 32'(out_prod), 32'(exp));
            chk("bp_ready", 32'(in_ready), 32'd0);
            chk("bp_array", 32'({bs_x, bs_y, bs_rin, bs_lastbit}), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("post_valid", 32'(out_valid), 32'd0);
        chk("post_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        int t0;
        int t1;
        int ovs;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_prod", 32'(out_prod), 32'd0);
        chk("rst_array_in", 32'({bs_x, bs_y, bs_rin}), 32'd0);
        chk("rst_lastbit", 32'(bs_lastbit), 32'd1);
        rst_n = 1'b1;
        #1;
        chk("init_lastbit", 32'(bs_lastbit), 32'd1);
        chk("init_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("idle_lastbit", 32'(bs_lastbit), 32'd0);
        chk("idle_ready", 32'(in_ready), 32'd1);
        chk("idle_valid", 32'(out_valid), 32'd0);

        run_op(8'd3, 8'd5, 16'h000F, 0, 1'b0, t0);
        run_op(8'hFF, 8'hFF, 16'hFE01, 0, 1'b0, t0);
        run_op(8'h00, 8'h5A, 16'h0000, 0, 1'b0, t0);
        run_op(8'h80, 8'h02, 16'h0100, 0, 1'b0, t0);
        run_op(8'h3C, 8'h0B, 16'h0294, 10, 1'b1, t0);

        // out_ready held high across both results
        run_op(8'h12, 8'h34, 16'h03A8, 0, 1'b0, t0);
        run_op(8'hAB, 8'hCD, 16'h88EF, 0, 1'b0, t1);
        chk("b2b_spacing", 32'(t1 - t0), 32'(2*W+LAT+3));

        for (int i = 0; i < 8; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            run_op(ra, rb, (2*W)'(ra) * (2*W)'(rb), i % 3, 1'b0, t0);
        end

        in_valid = 1'b1;
        in_a = 8'h6D;
        in_b = 8'hE3;
        @(negedge clk);
        in_valid = 1'b0;
        chk("abort_rin", 32'(bs_rin), 32'd1);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_lastbit", 32'(bs_lastbit), 32'd1);
        chk("abort_ready", 32'(in_ready), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        ovs = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (out_valid) ovs++;
        end
        chk("abort_no_valid", 32'(ovs), 32'd0);
        run_op(8'd7, 8'd9, 16'h003F, 0, 1'b0, t0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bs_mult_ctrl.md
# bs_mult_ctrl

Sequencing controller for the bit-serial multiplier array built from chained multiplier slices. It takes a pair of unsigned W-bit operands through a valid/ready handshake and streams them LSB-first into the array. It drives the array's row token (`bs_rin`) and clear strobe (`bs_lastbit`), captures the serial product stream into a 2W-bit register, and presents the result through a valid/ready handshake. It sits between the parallel host datapath and the serial array; one multiplication is in flight at a time.

## Interface
- `W`, default 8: operand width in bits; product is 2W bits.
- `LAT`, default 1: cycles from the array's first input bit (`bs_rin` cycle) to product bit 0 on `bs_p`; range 0..W.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous assert, active-low.
- `in_valid` input 1: operand pair valid.
- `in_ready` output 1: controller can accept operands.
- `in_a` input W: multiplicand, unsigned.
- `in_b` input W: multiplier, unsigned.
- `out_valid` output 1: `out_prod` valid.
- `out_ready` input 1: consumer accepts product.
- `out_prod` output 2W: product `in_a*in_b`.
- `bs_x` output 1: serial multiplicand bit to array.
- `bs_y` output 1: serial multiplier bit to array.
- `bs_rin` output 1: row-load token; high for the first bit cycle only.
- `bs_lastbit` output 1: synchronous clear of all array slice state.
- `bs_p` input 1: serial product bit from array, LSB first.

## Operation
- Registers: state, operand shift registers `sa`/`sb` (W), counter `cnt` (width clog2(2W+LAT+1)), product register `pr` (2W).
- States: INIT, IDLE, SHIFT, FLUSH, DONE.
- INIT: reset state; `bs_lastbit`=1 for exactly one cycle after `rst_n` release; then IDLE.
- IDLE: `in_ready`=1. On `in_valid`&`in_ready`: load `sa`=`in_a`, `sb`=`in_b`, `cnt`=0, `pr`=0; go to SHIFT.
- SHIFT, per cycle:
  - `bs_x`=`sa[0]`, `bs_y`=`sb[0]` while `cnt`<W; both 0 when `cnt`>=W.
  - `sa`/`sb` shift right with zero fill.
  - `bs_rin`=1 only when `cnt`==0.
  - When `cnt`>=LAT: sample `bs_p` into `pr` MSB, shift `pr` right.
  - `cnt` increments. At `cnt`==2W+LAT-1, take the final sample and go to FLUSH. After 2W samples, `pr[k]` holds product bit k.
- FLUSH: one cycle; `bs_lastbit`=1, `bs_x`=`bs_y`=0, no sampling; go to DONE.
- DONE: `out_valid`=1, `out_prod`=`pr` held stable. On `out_ready`, go to IDLE.
- `in_ready`=1 only in IDLE; `in_valid` outside IDLE is ignored and its operands are not latched.
- Arithmetic is unsigned; there is no overflow (2W bits is exact). Zero operands take the same full sequence length.

## Timing
- Reset values (async, while `rst_n`=0): state=INIT, `in_ready`=0, `out_valid`=0, `out_prod`=0, `bs_x`=`bs_y`=`bs_rin`=0, `bs_lastbit`=1 (array is held clear during reset).
- First accept is possible on the 2nd rising edge after `rst_n` deasserts (INIT → IDLE, then accept).
- Accept edge E0 → SHIFT cycles E0+1 … E0+2W+LAT → FLUSH at E0+2W+LAT+1 → `out_valid` high after edge E0+2W+LAT+2. For W=8, LAT=1: `out_valid` rises 19 cycles after accept.
- Throughput: one multiply per 2W+LAT+3 cycles with `out_ready` held high. DONE+`out_ready` → IDLE; the next accept is one cycle later.
- `out_valid`/`out_prod` hold indefinitely under backpressure; the array stays idle with `bs_lastbit`=0 and all array inputs 0.
- All outputs are registered except `in_ready`, which is decoded from state only (no combinational path from `in_valid` or `out_ready`).
- `rst_n` asserted mid-SHIFT/FLUSH/DONE: the transaction is aborted immediately, with no `out_valid` pulse, and the sequence restarts from INIT.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles, then release → `bs_lastbit`=1 through the first post-reset cycle; `in_ready` rises the next cycle; all other outputs 0.
- W=8, LAT=1, behavioural serial array model: `in_a`=3, `in_b`=5 → `bs_rin` high for exactly 1 cycle; `out_prod`=0x000F with `out_valid` 19 cycles after accept.
- Extremes: 0xFF×0xFF → 0xFE01; 0x00×0x5A → 0x0000; 0x80×0x02 → 0x0100. Each result is followed by a single `bs_lastbit` pulse before `out_valid`.
- Backpressure and busy: hold `out_ready`=0 for 10 cycles → `out_prod` stable, `in_ready`=0. Assert `in_valid` with 0x11×0x11 during SHIFT → ignored; the first result is unchanged.
- Back-to-back with `out_ready`=1: 0x12×0x34 then 0xAB×0xCD → 0x03A8 then 0x88EF, accepts spaced exactly 2W+LAT+3=20 cycles apart.
- Abort: drop `rst_n` at SHIFT `cnt`=5 → `out_valid` never asserts. A subsequent 7×9 → 0x003F is correct.
